// File: rtl/rsa_modexp.sv
// rtl/rsa_modexp.sv - left-to-right square-and-multiply modexp over a bit-serial modular multiplier
// Define MODEXP_CONST_TIME_EN to scan every exponent bit with dummy multiplies (fixed latency).
module rsa_modexp #(
   parameter int WIDTH = 2048
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] base,
   input  logic [WIDTH-1:0] exponent,
   input  logic [WIDTH-1:0] modulus,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             err
);

   localparam int IW = $clog2(WIDTH);
   localparam int CW = $clog2(WIDTH + 1);
   localparam int AW = WIDTH + 2;

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SQR, S_MUL, S_DONE} state_t;

   state_t           r_state, w_next;
   logic [WIDTH-1:0] r_b, r_e, r_n, r_r, r_result;
   logic [AW-1:0]    r_acc;
   logic [CW-1:0]    r_cnt;
   logic [IW-1:0]    r_i;
   logic             r_err;

   logic [IW-1:0]    w_xidx;
   logic             w_xbit, w_ebit, w_last, w_bad, w_ezero, w_go_mul, w_step, w_keep;
   logic [WIDTH-1:0] w_y, w_r_next;
   logic [AW-1:0]    w_nx, w_sum, w_red1, w_red2;

   assign in_ready  = (r_state == S_IDLE);
   assign out_valid = (r_state == S_DONE);
   assign result    = r_result;
   assign err       = r_err;

   // Multiplier: X=R scanned msb-first by the cycle counter, Y=R (square) or B (multiply).
   assign w_xidx  = IW'(WIDTH - 1) - r_cnt[IW-1:0];
   assign w_xbit  = r_r[w_xidx];
   assign w_y     = (r_state == S_MUL) ? r_b : r_r;
   assign w_nx    = {2'b00, r_n};
   assign w_sum   = (r_acc << 1) + (w_xbit ? {2'b00, w_y} : {AW{1'b0}});
   assign w_red1  = (w_sum >= w_nx) ? (w_sum - w_nx) : w_sum;
   assign w_red2  = (w_red1 >= w_nx) ? (w_red1 - w_nx) : w_red1;
   assign w_last  = (r_cnt == CW'(WIDTH));

   assign w_ebit  = r_e[r_i];
   assign w_bad   = (r_n < WIDTH'(2)) || (r_b >= r_n);
   assign w_ezero = (r_e == '0);

`ifdef MODEXP_CONST_TIME_EN
   assign w_go_mul = 1'b1;
`else
   logic [IW-1:0] w_msb;
   always_comb begin
      w_msb = '0;
      for (int k = 0; k < WIDTH; k++) begin
         if (r_e[k]) w_msb = IW'(k);
      end
   end
   assign w_go_mul = w_ebit;
`endif

   // A multiply result is kept unless it is a constant-time dummy multiply on a zero bit.
   assign w_keep   = (r_state == S_SQR) || w_ebit;
   assign w_r_next = w_keep ? r_acc[WIDTH-1:0] : r_r;
   assign w_step   = w_last && ((r_state == S_MUL) || ((r_state == S_SQR) && !w_go_mul));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: if (in_valid) w_next = S_LOAD;
         S_LOAD: w_next = (w_bad || w_ezero) ? S_DONE : S_SQR;
         S_SQR: begin
            if (w_last) begin
               if (w_go_mul)       w_next = S_MUL;
               else if (r_i == '0) w_next = S_DONE;
               else                w_next = S_SQR;
            end
         end
         S_MUL: if (w_last) w_next = (r_i == '0) ? S_DONE : S_SQR;
         S_DONE: if (out_ready) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_b      <= '0;
         r_e      <= '0;
         r_n      <= '0;
         r_r      <= '0;
         r_acc    <= '0;
         r_cnt    <= '0;
         r_i      <= '0;
         r_result <= '0;
         r_err    <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (in_valid) begin
                  r_b <= base;
                  r_e <= exponent;
                  r_n <= modulus;
               end
            end
            S_LOAD: begin
               r_acc <= '0;
               r_cnt <= '0;
               r_r   <= WIDTH'(1);
`ifdef MODEXP_CONST_TIME_EN
               r_i   <= IW'(WIDTH - 1);
`else
               r_i   <= w_msb;
`endif
               r_err <= w_bad;
               if (w_bad)        r_result <= '0;
               else if (w_ezero) r_result <= WIDTH'(1);
            end
            S_SQR, S_MUL: begin
               if (!w_last) begin
                  r_acc <= w_red2;
                  r_cnt <= r_cnt + CW'(1);
               end else begin
                  r_acc <= '0;
                  r_cnt <= '0;
                  r_r   <= w_r_next;
                  if (w_step) begin
                     if (r_i == '0) r_result <= w_r_next;
                     else           r_i      <= r_i - IW'(1);
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_rsa_modexp.sv
// tb/tb_rsa_modexp.sv - scoreboard bench for rsa_modexp at WIDTH=16
// Honours MODEXP_CONST_TIME_EN for the expected latency.
module tb_rsa_modexp;
   localparam int W = 16;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         out_ready = 1'b0;
   logic [W-1:0] base = '0, exponent = '0, modulus = '0;
   logic         in_ready, out_valid, err;
   logic [W-1:0] result;

   always #5 clk = ~clk;

   rsa_modexp #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .base(base), .exponent(exponent), .modulus(modulus),
      .out_valid(out_valid), .out_ready(out_ready), .result(result), .err(err)
   );

   int checks = 0;
   int failures = 0;
   logic [W-1:0] sb_res[$];
   logic         sb_err[$];
   int           sb_lat[$];

   function automatic logic [W-1:0] ref_modexp(input logic [W-1:0] b, input logic [W-1:0] e,
                                                input logic [W-1:0] n);
      longint unsigned r = 1;
      for (int k = W - 1; k >= 0; k--) begin
         r = (r * r) % n;
         if (e[k]) r = (r * b) % n;
      end
      return r[W-1:0];
   endfunction

   function automatic int ref_lat(input logic [W-1:0] b, input logic [W-1:0] e,
                                  input logic [W-1:0] n);
      int msb = 0;
      int pop = 0;
      if (n < 2 || b >= n || e == 0) return 2;
`ifdef MODEXP_CONST_TIME_EN
      return 2 + 2 * W * (W + 1);
`else
      for (int k = 0; k < W; k++) if (e[k]) begin msb = k; pop++; end
      return 2 + (msb + 1 + pop) * (W + 1);
`endif
   endfunction

   // Presents a request at a negedge, pushes the expectation, returns at the negedge after accept.
   task automatic issue(input logic [W-1:0] b, input logic [W-1:0] e, input logic [W-1:0] n);
      int guard = 0;
      while (!in_ready && guard < 100) begin @(negedge clk); guard++; end
      base = b; exponent = e; modulus = n; in_valid = 1'b1;
      if (n < 2 || b >= n) begin sb_res.push_back('0); sb_err.push_back(1'b1); end
      else begin sb_res.push_back(ref_modexp(b, e, n)); sb_err.push_back(1'b0); end
      sb_lat.push_back(ref_lat(b, e, n));
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      base = W'($urandom); exponent = W'($urandom); modulus = W'($urandom);
   endtask

   task automatic collect(input string name, input int hold, output logic [W-1:0] got);
      int cyc = 1;
      logic [W-1:0] er;
      logic ee;
      int el;
      logic stable;
      while (!out_valid && cyc < 3000) begin @(negedge clk); cyc++; end
      er = sb_res.pop_front(); ee = sb_err.pop_front(); el = sb_lat.pop_front();
      got = result;
      checks++;
      if (!out_valid) begin
         failures++;
         $display("FAIL %s timeout: out_valid=0 after %0d cycles, required 1", name, cyc);
         return;
      end
      checks++;
      if (result !== er) begin failures++; $display("FAIL %s result: got %0d required %0d", name, result, er); end
      checks++;
      if (err !== ee) begin failures++; $display("FAIL %s err: got %0b required %0b", name, err, ee); end
      checks++;
      if (cyc !== el) begin failures++; $display("FAIL %s latency: got %0d required %0d", name, cyc, el); end
      if (hold > 0) begin
         stable = 1'b1;
         for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            if (out_valid !== 1'b1 || result !== got || in_ready !== 1'b0) stable = 1'b0;
         end
         checks++;
         if (!stable) begin failures++; $display("FAIL %s backpressure: stable=%0b required 1", name, stable); end
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         failures++;
         $display("FAIL %s release: out_valid=%0b in_ready=%0b required 0 1", name, out_valid, in_ready);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({in_ready, out_valid, err, result} !== {1'b1, 1'b0, 1'b0, {W{1'b0}}}) begin
         failures++;
         $display("FAIL reset: in_ready=%0b out_valid=%0b err=%0b result=%0d required 1 0 0 0",
                  in_ready, out_valid, err, result);
      end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_known();
      logic [W-1:0] got;
      issue(16'd4, 16'd13, 16'd497);
      collect("known_4_13_497", 0, got);
      checks++;
      if (got !== 16'd445) begin failures++; $display("FAIL known_445: got %0d required 445", got); end
      issue(16'd65, 16'd17, 16'd3233);
      collect("rsa_enc", 0, got);
      checks++;
      if (got !== 16'd2790) begin failures++; $display("FAIL rsa_enc_const: got %0d required 2790", got); end
      issue(got, 16'd2753, 16'd3233);
      collect("rsa_dec", 0, got);
      checks++;
      if (got !== 16'd65) begin failures++; $display("FAIL rsa_dec_const: got %0d required 65", got); end
   endtask

   task automatic test_boundaries();
      logic [W-1:0] got;
      issue(16'd7, 16'd0, 16'd11);
      collect("exp_zero", 0, got);
      checks++;
      if (got !== 16'd1) begin failures++; $display("FAIL exp_zero_const: got %0d required 1", got); end
      issue(16'd11, 16'd5, 16'd11);
      collect("base_eq_mod", 0, got);
      issue(16'd0, 16'd3, 16'd1);
      collect("mod_one", 0, got);
      issue(16'd0, 16'd3, 16'd0);
      collect("mod_zero", 0, got);
      issue(16'd65534, 16'hFFFF, 16'd65535);
      collect("max_operands", 0, got);
      issue(16'd0, 16'd5, 16'd2);
      collect("base_zero", 0, got);
      issue(16'd1, 16'd1, 16'd2);
      collect("exp_one", 0, got);
   endtask

   task automatic test_backpressure();
      logic [W-1:0] got;
      issue(16'd123, 16'd77, 16'd1000);
      collect("backpressure", 20, got);
   endtask

   task automatic test_back_to_back();
      logic [W-1:0] got;
      int cyc = 1;
      issue(16'd65, 16'd17, 16'd3233);
      while (!out_valid && cyc < 3000) begin @(negedge clk); cyc++; end
      got = result;
      void'(sb_res.pop_front()); void'(sb_err.pop_front()); void'(sb_lat.pop_front());
      checks++;
      if (out_valid !== 1'b1 || got !== 16'd2790) begin
         failures++;
         $display("FAIL b2b_first: out_valid=%0b result=%0d required 1 2790", out_valid, got);
      end
      out_ready = 1'b1; in_valid = 1'b1;
      base = 16'd2790; exponent = 16'd2753; modulus = 16'd3233;
      @(negedge clk);
      out_ready = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         failures++;
         $display("FAIL b2b_idle: out_valid=%0b in_ready=%0b required 0 1", out_valid, in_ready);
      end
      in_valid = 1'b0;
      issue(16'd2790, 16'd2753, 16'd3233);
      collect("b2b_second", 0, got);
      checks++;
      if (got !== 16'd65) begin failures++; $display("FAIL b2b_second_const: got %0d required 65", got); end
   endtask

   task automatic test_midop_reset();
      logic [W-1:0] got;
      issue(16'd4, 16'd13, 16'd497);
      repeat (40) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || result !== '0) begin
         failures++;
         $display("FAIL midop_reset: out_valid=%0b in_ready=%0b result=%0d required 0 1 0",
                  out_valid, in_ready, result);
      end
      void'(sb_res.pop_back()); void'(sb_err.pop_back()); void'(sb_lat.pop_back());
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      issue(16'd4, 16'd13, 16'd497);
      collect("after_reset", 0, got);
      checks++;
      if (got !== 16'd445) begin failures++; $display("FAIL after_reset_const: got %0d required 445", got); end
   endtask

   task automatic test_random();
      logic [W-1:0] got, n, b, e;
      for (int k = 0; k < 14; k++) begin
         n = W'($urandom_range(65535, 2));
         b = W'($urandom_range(32'(n) - 1, 0));
         e = W'($urandom);
         if (k == 3) e = 16'h0001;
         if (k == 7) e = 16'h8000;
         issue(b, e, n);
         collect($sformatf("random_%0d", k), 0, got);
      end
   endtask

   initial begin
      test_reset();
      test_known();
      test_boundaries();
      test_backpressure();
      test_back_to_back();
      test_midop_reset();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #5000000;
      $display("FAIL global_timeout: simulation exceeded time limit");
      $fatal(1);
   end
endmodule
